// File: rtl/gumnut_alu_pkg.sv
// Shared encodings for the Gumnut sequential ALU: function codes for both op
// classes and the controller state type.
package gumnut_alu_pkg;

    localparam logic [2:0] FN_ADD  = 3'd0;
    localparam logic [2:0] FN_ADDC = 3'd1;
    localparam logic [2:0] FN_SUB  = 3'd2;
    localparam logic [2:0] FN_SUBC = 3'd3;
    localparam logic [2:0] FN_AND  = 3'd4;
    localparam logic [2:0] FN_OR   = 3'd5;
    localparam logic [2:0] FN_XOR  = 3'd6;
    localparam logic [2:0] FN_MASK = 3'd7;

    localparam logic [1:0] SH_SHL = 2'd0;
    localparam logic [1:0] SH_SHR = 2'd1;
    localparam logic [1:0] SH_ROL = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/gumnut_alu_arith.sv
// Combinational add/sub/logic core. Returns {carry, value}; for subtraction
// the top bit is the borrow, for logic ops it is always 0.
module gumnut_alu_arith
    import gumnut_alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        func,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W:0]   res
);

    logic [DATA_W:0] a_x;
    logic [DATA_W:0] b_x;
    logic [DATA_W:0] c_x;

    assign a_x = {1'b0, a};
    assign b_x = {1'b0, b};
    assign c_x = {{DATA_W{1'b0}}, cin};

    // DATA_W+1 bit wrap makes the top bit the carry on add and the borrow on sub
    always_comb begin
        res = '0;
        case (func)
            FN_ADD:  res = a_x + b_x;
            FN_ADDC: res = a_x + b_x + c_x;
            FN_SUB:  res = a_x - b_x;
            FN_SUBC: res = a_x - b_x - c_x;
            FN_AND:  res = {1'b0, a & b};
            FN_OR:   res = {1'b0, a | b};
            FN_XOR:  res = {1'b0, a ^ b};
            FN_MASK: res = {1'b0, a & ~b};
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/gumnut_alu_seq.sv
// Registered Gumnut ALU with start/busy/done handshake; arith/logic in one
// cycle, shifts and rotates one bit per clock with persistent C/Z flags.
//
// state | meaning
// IDLE  | waiting for start; operands sampled on acceptance
// SHIFT | one 1-bit step per cycle, cnt counts down to 1
// DONE  | one-cycle done pulse, result and flags valid
module gumnut_alu_seq
    import gumnut_alu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               op_shift,
    input  logic [2:0]         func,
    input  logic [DATA_W-1:0]  rs_val,
    input  logic [DATA_W-1:0]  op2,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  result,
    output logic               zero_flag,
    output logic               carry_flag
);

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   sh_reg;
    logic [SHAMT_W-1:0]  cnt;
    logic [1:0]          sh_func;
    logic [DATA_W:0]     arith_res;
    logic [DATA_W-1:0]   step_val;
    logic                step_out;
    logic                accept;
    logic                last_step;

    assign accept    = (state == ST_IDLE) && start;
    assign last_step = (state == ST_SHIFT) && (cnt == SHAMT_W'(1));
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    gumnut_alu_arith #(.DATA_W(DATA_W)) u_arith (
        .func (func),
        .a    (rs_val),
        .b    (op2),
        .cin  (carry_flag),
        .res  (arith_res)
    );

    always_comb begin
        step_val = sh_reg;
        step_out = 1'b0;
        case (sh_func)
            SH_SHL: begin step_val = {sh_reg[DATA_W-2:0], 1'b0};          step_out = sh_reg[DATA_W-1]; end
            SH_SHR: begin step_val = {1'b0, sh_reg[DATA_W-1:1]};          step_out = sh_reg[0];        end
            SH_ROL: begin step_val = {sh_reg[DATA_W-2:0], sh_reg[DATA_W-1]}; step_out = sh_reg[DATA_W-1]; end
            SH_ROR: begin step_val = {sh_reg[0], sh_reg[DATA_W-1:1]};     step_out = sh_reg[0];        end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (op_shift && (shamt != '0)) state_nxt = ST_SHIFT;
                    else                           state_nxt = ST_DONE;
                end
            end
            ST_SHIFT: if (cnt == SHAMT_W'(1)) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // result/flags are only written on the edge that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_reg     <= '0;
            cnt        <= '0;
            sh_func    <= SH_SHL;
            result     <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else if (accept) begin
            sh_reg  <= rs_val;
            cnt     <= shamt;
            sh_func <= func[1:0];
            if (!op_shift) begin
                result     <= arith_res[DATA_W-1:0];
                carry_flag <= arith_res[DATA_W];
                zero_flag  <= (arith_res[DATA_W-1:0] == '0);
            end else if (shamt == '0) begin
                result     <= rs_val;
                carry_flag <= 1'b0;
                zero_flag  <= (rs_val == '0);
            end
        end else if (state == ST_SHIFT) begin
            sh_reg <= step_val;
            cnt    <= cnt - SHAMT_W'(1);
            if (last_step) begin
                result     <= step_val;
                carry_flag <= step_out;
                zero_flag  <= (step_val == '0);
            end
        end
    end

endmodule

// File: tb/tb_gumnut_alu_seq.sv
// Self-checking bench for gumnut_alu_seq at DATA_W=8 and DATA_W=16, using an
// arithmetic reference model of the ALU rules.
module tb_gumnut_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0, opsh8 = 1'b0;
    logic [2:0]  func8 = '0;
    logic [7:0]  rs8 = '0, op28 = '0;
    logic [2:0]  shamt8 = '0;
    logic        busy8, done8, z8, c8;
    logic [7:0]  res8;

    logic        start16 = 1'b0, opsh16 = 1'b0;
    logic [2:0]  func16 = '0;
    logic [15:0] rs16 = '0, op216 = '0;
    logic [3:0]  shamt16 = '0;
    logic        busy16, done16, z16, c16;
    logic [15:0] res16;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gumnut_alu_seq #(.DATA_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op_shift(opsh8), .func(func8),
        .rs_val(rs8), .op2(op28), .shamt(shamt8), .busy(busy8), .done(done8),
        .result(res8), .zero_flag(z8), .carry_flag(c8)
    );

    gumnut_alu_seq #(.DATA_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .op_shift(opsh16), .func(func16),
        .rs_val(rs16), .op2(op216), .shamt(shamt16), .busy(busy16), .done(done16),
        .result(res16), .zero_flag(z16), .carry_flag(c16)
    );

    typedef struct {
        bit     sh;
        int     f;
        longint a;
        longint b;
        int     n;
        bit     spam;
        longint er;
        bit     ez;
        bit     ec;
        int     el;
    } vec_t;

    // Reference: plain integer arithmetic on the operation's definition.
    function automatic void model(input int w, input bit sh, input int f, input longint a,
                                  input longint b, input int n, input bit cin,
                                  output longint r, output bit c);
        longint m = (longint'(1) << w) - 1;
        longint t;
        r = 0; c = 0;
        if (!sh) begin
            case (f)
                0: t = a + b;
                1: t = a + b + longint'(cin);
                2: t = a - b;
                3: t = a - b - longint'(cin);
                4: t = a & b;
                5: t = a | b;
                6: t = a ^ b;
                default: t = a & ~b & m;
            endcase
            r = t & m;
            c = (f < 4) && ((t > m) || (t < 0));
        end else if (n == 0) begin
            r = a;
            c = 0;
        end else begin
            case (f % 4)
                0: begin r = (a << n) & m;                   c = bit'((a >> (w - n)) & 1); end
                1: begin r = a >> n;                         c = bit'((a >> (n - 1)) & 1); end
                2: begin r = ((a << n) | (a >> (w - n))) & m; c = bit'(r & 1); end
                default: begin r = ((a >> n) | (a << (w - n))) & m; c = bit'((r >> (w - 1)) & 1); end
            endcase
        end
    endfunction

    task automatic drive(input bit w16, input bit st, input bit sh, input int f,
                         input longint a, input longint b, input int n);
        if (w16) begin
            start16 = st; opsh16 = sh; func16 = f[2:0];
            rs16 = a[15:0]; op216 = b[15:0]; shamt16 = n[3:0];
        end else begin
            start8 = st; opsh8 = sh; func8 = f[2:0];
            rs8 = a[7:0]; op28 = b[7:0]; shamt8 = n[2:0];
        end
    endtask

    // Issues one op, scrambles inputs after acceptance, and watches a fixed window.
    task automatic do_op(input bit w16, input bit sh, input int f, input longint a,
                         input longint b, input int n, input bit spam,
                         output longint r, output bit z, output bit c,
                         output int first, output int ndone, output longint held);
        bit d;
        r = 0; z = 0; c = 0; first = -1; ndone = 0;
        @(negedge clk);
        drive(w16, 1'b1, sh, f, a, b, n);
        @(posedge clk); #1;
        drive(w16, spam, 1'($urandom), int'($urandom_range(7, 0)), longint'($urandom),
              longint'($urandom), int'($urandom_range(15, 0)));
        for (int k = 1; k <= n + 4; k++) begin
            if (first >= 0 && k > first) begin
                if (w16) start16 = 1'b0; else start8 = 1'b0;
            end
            d = w16 ? done16 : done8;
            if (d) begin
                ndone++;
                if (first < 0) begin
                    first = k;
                    if (w16) begin r = longint'(res16); z = z16; c = c16; end
                    else     begin r = longint'(res8);  z = z8;  c = c8;  end
                end
            end
            @(posedge clk); #1;
        end
        if (w16) begin held = longint'(res16); start16 = 1'b0; end
        else     begin held = longint'(res8);  start8  = 1'b0; end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy8, done8, res8, z8, c8} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_w8: got busy=%b done=%b result=%h z=%b c=%b, want all 0",
                     busy8, done8, res8, z8, c8);
        end
        n_checks++;
        if ({busy16, done16, res16, z16, c16} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_w16: got busy=%b done=%b result=%h z=%b c=%b, want all 0",
                     busy16, done16, res16, z16, c16);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed(input bit w16);
        vec_t v[$];
        longint r, held;
        bit z, c;
        int first, ndone;
        if (!w16) begin
            v.push_back('{0, 0, 'h05, 'h05, 0, 0, 'h0A, 0, 0, 1});
            v.push_back('{0, 2, 'h05, 'h05, 0, 0, 'h00, 1, 0, 1});
            v.push_back('{0, 2, 'h03, 'h05, 0, 0, 'hFE, 0, 1, 1});
            v.push_back('{0, 0, 'hFF, 'h01, 0, 0, 'h00, 1, 1, 1});
            v.push_back('{0, 1, 'h01, 'h01, 0, 0, 'h03, 0, 0, 1});
            v.push_back('{1, 0, 'hC0, 'h00, 2, 1, 'h00, 1, 1, 3});
        end else begin
            v.push_back('{0, 0, 'hFFFF, 'h0001, 0, 0, 'h0000, 1, 1, 1});
            v.push_back('{1, 2, 'h8001, 'h0000, 4, 0, 'h0018, 0, 0, 5});
            v.push_back('{1, 3, 'h0001, 'h0000, 0, 0, 'h0001, 0, 0, 1});
        end
        foreach (v[i]) begin
            do_op(w16, v[i].sh, v[i].f, v[i].a, v[i].b, v[i].n, v[i].spam,
                  r, z, c, first, ndone, held);
            n_checks++;
            if (r !== v[i].er) begin
                n_fail++; $display("FAIL dir_result w16=%0d #%0d: got %h want %h", w16, i, r, v[i].er);
            end
            n_checks++;
            if (z !== v[i].ez || c !== v[i].ec) begin
                n_fail++; $display("FAIL dir_flags w16=%0d #%0d: got z=%b c=%b want z=%b c=%b",
                                   w16, i, z, c, v[i].ez, v[i].ec);
            end
            n_checks++;
            if (first !== v[i].el) begin
                n_fail++; $display("FAIL dir_latency w16=%0d #%0d: got %0d want %0d", w16, i, first, v[i].el);
            end
            n_checks++;
            if (ndone !== 1) begin
                n_fail++; $display("FAIL dir_done_count w16=%0d #%0d: got %0d want 1", w16, i, ndone);
            end
            n_checks++;
            if (held !== v[i].er) begin
                n_fail++; $display("FAIL dir_held w16=%0d #%0d: got %h want %h", w16, i, held, v[i].er);
            end
        end
    endtask

    task automatic test_reset_abort;
        longint r, held;
        bit z, c;
        int first, ndone, seen;
        seen = 0;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1, 'hF0, 0, 7);
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (done8) seen++;
            if (k < 3) begin @(posedge clk); #1; end
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy8, done8, res8, z8, c8} !== 12'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: got busy=%b done=%b result=%h z=%b c=%b, want all 0",
                     busy8, done8, res8, z8, c8);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (done8) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL abort_no_done: got %0d done cycles want 0", seen);
        end
        do_op(0, 1'b0, 4, 'h0F, 'h3C, 0, 1'b0, r, z, c, first, ndone, held);
        n_checks++;
        if (r !== 'h0C || z !== 1'b0 || c !== 1'b0 || first !== 1) begin
            n_fail++;
            $display("FAIL abort_then_and: got result=%h z=%b c=%b lat=%0d want 0c 0 0 1", r, z, c, first);
        end
    endtask

    task automatic test_random(input bit w16, input int nops);
        int w = w16 ? 16 : 8;
        longint m = (longint'(1) << w) - 1;
        bit mc = 1'b0;
        longint a, b, er, r, held;
        bit sh, spam, ec, ez, z, c;
        int f, n, el, first, ndone;
        for (int i = 0; i < nops; i++) begin
            sh   = 1'($urandom_range(1, 0));
            f    = int'($urandom_range(7, 0));
            a    = longint'($urandom) & m;
            b    = longint'($urandom) & m;
            n    = int'($urandom_range(w - 1, 0));
            spam = ($urandom_range(3, 0) == 0);
            model(w, sh, f, a, b, n, mc, er, ec);
            ez = (er == 0);
            el = (sh && n != 0) ? n + 1 : 1;
            do_op(w16, sh, f, a, b, n, spam, r, z, c, first, ndone, held);
            n_checks++;
            if (r !== er || z !== ez || c !== ec) begin
                n_fail++;
                $display("FAIL rnd w16=%0d #%0d sh=%0d f=%0d a=%h b=%h n=%0d: got %h z=%b c=%b want %h z=%b c=%b",
                         w16, i, sh, f, a, b, n, r, z, c, er, ez, ec);
            end
            n_checks++;
            if (first !== el || ndone !== 1) begin
                n_fail++;
                $display("FAIL rnd_timing w16=%0d #%0d: got lat=%0d dones=%0d want lat=%0d dones=1",
                         w16, i, first, ndone, el);
            end
            n_checks++;
            if (held !== er) begin
                n_fail++; $display("FAIL rnd_held w16=%0d #%0d: got %h want %h", w16, i, held, er);
            end
            mc = ec;
        end
    endtask

    initial begin
        test_reset();
        test_directed(1'b0);
        test_reset_abort();
        test_directed(1'b1);
        test_random(1'b0, 40);
        test_random(1'b1, 30);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
